// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Drives an N-digit BCD value onto a seven-segment display, one digit at a
// time. The segment and digit-enable outputs are both registered. New values
// arrive through a valid/ready handshake. They go into a pending register
// and are copied into the display register only at a frame boundary, or
// while the display is idle, so a frame never shows a mix of old and new
// digits.
//
// Parameters:
//   NUM_DIGITS  - number of digits scanned (1..8)
//   REFRESH_DIV - clock cycles each digit is held (>= 2)
//
// Ports:
//   clk        - system clock, rising-edge active
//   rst_n      - asynchronous active-low reset
//   enable     - 1 = scan the display, 0 = blank outputs and hold counters at 0
//   load_valid - producer offers load_data this cycle
//   load_ready - block can accept a value (no value pending)
//   load_data  - packed BCD value, digit i at [4i+3:4i], digit 0 rightmost
//   seg        - segment drive {g,f,e,d,c,b,a}, 1 = lit, registered
//   dig_en     - one-hot active-high digit select, registered
//
// Optional build macro:
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN - when defined, blanks the segments of
//   leading zero digits. A digit i>0 is blanked when it and every digit above
//   it are zero. Digit 0 is always shown. dig_en keeps scanning normally.
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PRE_W-1:0]       pre_q, pre_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VAL_W-1:0]       disp_q, disp_d;
    logic [VAL_W-1:0]       pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [6:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  dig_en_q, dig_en_d;

    logic                   at_wrap;
    logic                   commit;

    // BCD to {g,f,e,d,c,b,a}. Codes 10..15 show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] digit_at(input logic [VAL_W-1:0] val,
                                            input logic [IDX_W-1:0] idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) d = val[4*i +: 4];
        end
        return d;
    endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Walk down from the most significant digit. The running flag stays set
    // while every digit seen so far is zero. Digit 0 is never blanked.
    function automatic logic is_leading_zero(input logic [VAL_W-1:0] val,
                                             input logic [IDX_W-1:0] idx);
        logic upper_zero;
        logic blank;
        upper_zero = 1'b1;
        blank      = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (val[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) blank = upper_zero;
        end
        return blank;
    endfunction

    function automatic logic [6:0] seg_for(input logic [VAL_W-1:0] val,
                                           input logic [IDX_W-1:0] idx);
        return is_leading_zero(val, idx) ? 7'h00 : bcd_to_seg(digit_at(val, idx));
    endfunction
`else
    function automatic logic [6:0] seg_for(input logic [VAL_W-1:0] val,
                                           input logic [IDX_W-1:0] idx);
        return bcd_to_seg(digit_at(val, idx));
    endfunction
`endif

    assign at_wrap = (pre_q == PRE_MAX);

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        idx_d      = idx_q;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        commit     = 1'b0;

        case (state_q)
            IDLE: begin
                // Idle always commits, so a value loaded while blanked is
                // ready when scanning starts.
                pre_d  = '0;
                idx_d  = '0;
                commit = 1'b1;
                if (enable) state_d = SCAN;
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                    pre_d   = '0;
                    idx_d   = '0;
                    commit  = 1'b1;
                end else if (at_wrap) begin
                    pre_d  = '0;
                    idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                    commit = (idx_q == IDX_MAX);
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pre_d   = '0;
                idx_d   = '0;
            end
        endcase

        // A commit needs a pending value and a transfer needs an empty
        // pending slot, so both can never happen on the same edge. A value
        // accepted on a boundary therefore waits for the next boundary.
        if (commit && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end else if (load_valid && !pend_vld_q) begin
            pend_d     = load_data;
            pend_vld_d = 1'b1;
        end

        // Outputs are registered from the next-state index and display, so
        // they line up with the counters on the following cycle.
        seg_d    = '0;
        dig_en_d = '0;
        if (state_d == SCAN) begin
            seg_d = seg_for(disp_d, idx_d);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig_en_d[i] = (idx_d == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= '0;
            dig_en_q   <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            dig_en_q   <= dig_en_d;
        end
    end

    assign load_ready = ~pend_vld_q;
    assign seg        = seg_q;
    assign dig_en     = dig_en_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Directed bench for seven_segment_scanner with NUM_DIGITS=4 and
// REFRESH_DIV=4. Each table row holds inputs for one clock edge and the
// outputs expected just after that edge. Hand-written sequences cover
// asynchronous reset mid-frame and the optional leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [6:0]  seg;
    logic [3:0]  dig_en;

    int checks = 0;
    int errors = 0;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZERO_HI = 7'h00;
`else
    localparam logic [6:0] ZERO_HI = 7'h3F;
`endif

    seven_segment_scanner #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .seg       (seg),
        .dig_en    (dig_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        en;
        logic        lv;
        logic [15:0] ld;
        logic [6:0]  seg;
        logic [3:0]  dig;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input logic en, input logic lv,
                                input logic [15:0] ld, input logic [6:0] s,
                                input logic [3:0] d, input logic r);
        vec_t v;
        v.name = nm; v.en = en; v.lv = lv; v.ld = ld;
        v.seg = s; v.dig = d; v.rdy = r;
        vecs.push_back(v);
    endfunction

    // n scanning cycles with no load offered.
    function automatic void add_run(input string nm, input int n,
                                    input logic [6:0] s, input logic [3:0] d,
                                    input logic r);
        for (int i = 0; i < n; i++) add(nm, 1'b1, 1'b0, 16'h0, s, d, r);
    endfunction

    task automatic step(input logic en, input logic lv, input logic [15:0] ld);
        enable     = en;
        load_valid = lv;
        load_data  = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [6:0] eseg,
                             input logic [3:0] edig, input logic erdy);
        checks++;
        if (seg !== eseg) begin
            errors++;
            $display("FAIL %s: seg=%h expected %h", name, seg, eseg);
        end
        checks++;
        if (dig_en !== edig) begin
            errors++;
            $display("FAIL %s: dig_en=%b expected %b", name, dig_en, edig);
        end
        checks++;
        if (load_ready !== erdy) begin
            errors++;
            $display("FAIL %s: load_ready=%b expected %b", name, load_ready, erdy);
        end
    endtask

    initial begin
        // Scan from reset with an all-zero display.
        add_run("zero_d0", 4, 7'h3F,   4'b0001, 1'b1);
        add_run("zero_d1", 4, ZERO_HI, 4'b0010, 1'b1);
        add_run("zero_d2", 4, ZERO_HI, 4'b0100, 1'b1);
        add_run("zero_d3", 4, ZERO_HI, 4'b1000, 1'b1);
        add_run("zero_wrap", 1, 7'h3F, 4'b0001, 1'b1);
        // Load while idle, so it commits on the next edge.
        add("idle_blank",  1'b0, 1'b0, 16'h0,    7'h00, 4'b0000, 1'b1);
        add("idle_load",   1'b0, 1'b1, 16'h1234, 7'h00, 4'b0000, 1'b0);
        add("idle_commit", 1'b0, 1'b0, 16'h0,    7'h00, 4'b0000, 1'b1);
        add_run("v1234_d0", 4, 7'h66, 4'b0001, 1'b1);
        add_run("v1234_d1", 4, 7'h4F, 4'b0010, 1'b1);
        add_run("v1234_d2", 4, 7'h5B, 4'b0100, 1'b1);
        add_run("v1234_d3", 4, 7'h06, 4'b1000, 1'b1);
        // Load at digit 1 mid-frame. A second offer while busy is ignored.
        add_run("f2_d0", 4, 7'h66, 4'b0001, 1'b1);
        add_run("f2_d1", 1, 7'h4F, 4'b0010, 1'b1);
        add("scan_load",    1'b1, 1'b1, 16'h5678, 7'h4F, 4'b0010, 1'b0);
        add("scan_ignored", 1'b1, 1'b1, 16'h9999, 7'h4F, 4'b0010, 1'b0);
        add("scan_wait",    1'b1, 1'b0, 16'h0,    7'h4F, 4'b0010, 1'b0);
        add_run("wait_d2", 4, 7'h5B, 4'b0100, 1'b0);
        add_run("wait_d3", 4, 7'h06, 4'b1000, 1'b0);
        add_run("v5678_d0", 4, 7'h7F, 4'b0001, 1'b1);
        add_run("v5678_d1", 4, 7'h07, 4'b0010, 1'b1);
        add_run("v5678_d2", 4, 7'h7D, 4'b0100, 1'b1);
        add_run("v5678_d3", 4, 7'h6D, 4'b1000, 1'b1);
        // Accept on a frame-boundary edge; it must wait a whole frame.
        add("bnd_load", 1'b1, 1'b1, 16'h1B90, 7'h7F, 4'b0001, 1'b0);
        add_run("bnd_d0", 3, 7'h7F, 4'b0001, 1'b0);
        add_run("bnd_d1", 4, 7'h07, 4'b0010, 1'b0);
        add_run("bnd_d2", 4, 7'h7D, 4'b0100, 1'b0);
        add_run("bnd_d3", 4, 7'h6D, 4'b1000, 1'b0);
        add_run("v1B90_d0", 4, 7'h3F, 4'b0001, 1'b1);
        add_run("v1B90_d1", 4, 7'h6F, 4'b0010, 1'b1);
        add_run("v1B90_dash", 4, 7'h40, 4'b0100, 1'b1);
        add_run("v1B90_d3", 4, 7'h06, 4'b1000, 1'b1);
        // Drop enable with a value pending; it commits on the same edge.
        add_run("f5_d0", 1, 7'h3F, 4'b0001, 1'b1);
        add("f5_load",    1'b1, 1'b1, 16'h0042, 7'h3F, 4'b0001, 1'b0);
        add("f5_disable", 1'b0, 1'b0, 16'h0,    7'h00, 4'b0000, 1'b1);
        add_run("v0042_d0", 4, 7'h5B, 4'b0001, 1'b1);
        add_run("v0042_d1", 2, 7'h66, 4'b0010, 1'b1);
        add("pend_before_rst", 1'b1, 1'b1, 16'h9999, 7'h66, 4'b0010, 1'b0);

        rst_n      = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 7'h00, 4'b0000, 1'b1);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].lv, vecs[i].ld);
            check_out($sformatf("%s[%0d]", vecs[i].name, i),
                      vecs[i].seg, vecs[i].dig, vecs[i].rdy);
        end

        // Asynchronous reset mid-digit with 16'h9999 pending.
        enable     = 1'b1;
        load_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_out("rst_async", 7'h00, 4'b0000, 1'b1);
        @(posedge clk);
        #1 check_out("rst_hold", 7'h00, 4'b0000, 1'b1);
        #2 rst_n = 1'b1;
        // The pending value must be gone, so the display shows zeros from digit 0.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'h0);
            check_out("post_rst_d0", 7'h3F, 4'b0001, 1'b1);
        end
        step(1'b1, 1'b0, 16'h0);
        check_out("post_rst_d1", ZERO_HI, 4'b0010, 1'b1);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0050);
        step(1'b0, 1'b0, 16'h0);
        check_out("lzb_commit", 7'h00, 4'b0000, 1'b1);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 1'b0, 16'h0);
                check_out("lzb_0050", (d == 0) ? 7'h3F : (d == 1) ? 7'h6D : 7'h00,
                          4'(1 << d), 1'b1);
            end
        end
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 1'b0, 16'h0);
                check_out("lzb_0000", (d == 0) ? 7'h3F : 7'h00, 4'(1 << d), 1'b1);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Parametrised multi-digit, time-multiplexed BCD seven-segment display driver. It is the sequential successor to the team's single-digit BCD decoder.
- Holds an N-digit BCD value and scans one digit at a time, with a registered one-hot digit enable and registered segment drive.
- New values are accepted through a valid/ready handshake and committed only at a frame boundary, so the display never shows a torn value.
- Sits between datapath/status logic and the board's display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 1000, clock cycles each digit is held; must be >= 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan display; 0 = blank outputs and hold counters at 0.
- load_valid  in  1  producer offers load_data this cycle.
- load_ready  out  1  block can accept a value; equals ~pending_valid.
- load_data  in  4*NUM_DIGITS  packed BCD value; digit i = bits [4i+3:4i]; digit 0 is least significant (rightmost).
- seg  out  7  segment drive {g,f,e,d,c,b,a}; 1 = lit; registered.
- dig_en  out  NUM_DIGITS  one-hot active-high digit select; registered.

Behaviour:
- Reset (async, rst_n=0):
  - seg=0, dig_en=0, load_ready=1.
  - Display register=0, pending register=0, pending_valid=0.
  - Prescaler=0, digit index=0, state=IDLE.
- Handshake:
  - A transfer occurs on a clk edge where load_valid=1 and load_ready=1. load_data is captured into the pending register and pending_valid is set.
  - load_valid while load_ready=0 is ignored; the producer must hold its value.
- Commit: the pending value is copied to the display register and pending_valid is cleared on:
  - a frame-boundary edge in SCAN, or
  - any edge while in IDLE.
- load_ready returns to 1 the cycle after commit.
- A value accepted on a frame-boundary edge is not committed on that edge; it waits for the next boundary.
- States:
  - IDLE: seg=0, dig_en=0, prescaler=0, index=0. IDLE -> SCAN on an edge where enable=1.
  - SCAN: prescaler counts 0..REFRESH_DIV-1. On the edge where it reaches REFRESH_DIV-1, it wraps to 0 and the index advances.
  - Index counts 0..NUM_DIGITS-1 and wraps to 0.
  - Frame boundary = prescaler==REFRESH_DIV-1 and index==NUM_DIGITS-1.
  - SCAN -> IDLE on any edge where enable=0. Outputs blank on the following cycle; a pending value commits on that same edge.
- Output timing:
  - dig_en=one-hot(index) and seg=decode(display digit[index]) are registered from the next-state index/display values.
  - First digit 0 drive appears in the cycle after enable is sampled high.
  - Each digit is held exactly REFRESH_DIV cycles; a frame is NUM_DIGITS*REFRESH_DIV cycles.
  - A committed value is visible starting with digit 0 of the next frame.
- Decode (gfedcba hex):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Illegal codes 10..15 show dash 40.
- Widths: prescaler width $clog2(REFRESH_DIV); index width $clog2(NUM_DIGITS), minimum 1.
- Reset mid-frame: immediate blanking. Any pending value is discarded.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: any digit i>0 whose code is 0 and all of whose higher digits are 0 drives seg=00; dig_en still scans it. Digit 0 is always displayed, so an all-zero value shows a single "0".
- Not defined: all digits are decoded normally, including leading zeros.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4 unless stated):
- Reset then enable=1 with no load -> dig_en cycles 0001,0010,0100,1000, each for 4 cycles; seg=3F throughout; load_ready=1.
- load 16'h1234 while enable=0 -> committed next edge. After enable: digit0 seg=66, digit1 4F, digit2 5B, digit3 06.
- During SCAN, load 16'h5678 at index 1 -> load_ready=0 until the boundary; new value starts at the next digit0 (seg=7F); second load_valid during that wait is ignored.
- load_data digit code 4'hB -> that digit shows seg=40.
- Drop enable mid-frame, then assert rst_n=0 mid-frame -> blank the following cycle / immediately; counters and pending cleared; load_ready=1.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN defined, load 16'h0050 -> digits 3,2 seg=00, digit1=6D, digit0=3F. Load 16'h0000 -> only digit0 shows 3F.
